// File: rtl/exp_mul_axi4_lite_master.sv
// rtl/exp_mul_axi4_lite_master.sv - AXI4-Lite master running one job on the exponent/multiplier peripheral
// Optional feature macro: POLL_TIMEOUT_EN (bounds DONE polling to TIMEOUT_CYCLES).
module exp_mul_axi4_lite_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h7440_0000,
    parameter int unsigned POLL_GAP       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        i_start_job,
    input  logic [3:0]  i_A,
    input  logic [3:0]  i_B,
    input  logic        i_select,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [29:0] o_P,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    localparam logic [31:0] OFF_A     = 32'h00;
    localparam logic [31:0] OFF_B     = 32'h04;
    localparam logic [31:0] OFF_SEL   = 32'h08;
    localparam logic [31:0] OFF_START = 32'h0C;
    localparam logic [31:0] OFF_P     = 32'h10;
    localparam logic [31:0] OFF_DONE  = 32'h14;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_SEL,
        S_WR_START,
        S_POLL,
        S_GAP,
        S_RD_P,
        S_FINISH
    } state_t;

    state_t      state;
    state_t      next_wr;
    logic [3:0]  a_q;
    logic [3:0]  b_q;
    logic        sel_q;
    logic        xfer_active;   // a transaction has been launched in the current state
    logic        aw_done;
    logic        w_done;
    logic [7:0]  gap_cnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_addr;
    logic        timed_out;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_hs  = M_AXI_BREADY  & M_AXI_BVALID;
    assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs  = M_AXI_RREADY  & M_AXI_RVALID;

    // Address, data and successor state for whichever register write the FSM is on
    always_comb begin
        wr_addr = BASE_ADDR + OFF_A;
        wr_data = {28'b0, a_q};
        next_wr = S_WR_B;
        case (state)
            S_WR_B: begin
                wr_addr = BASE_ADDR + OFF_B;
                wr_data = {28'b0, b_q};
                next_wr = S_WR_SEL;
            end
            S_WR_SEL: begin
                wr_addr = BASE_ADDR + OFF_SEL;
                wr_data = {31'b0, sel_q};
                next_wr = S_WR_START;
            end
            S_WR_START: begin
                wr_addr = BASE_ADDR + OFF_START;
                wr_data = 32'h1;
                next_wr = S_POLL;
            end
            default: ;
        endcase
    end

    assign rd_addr = (state == S_RD_P) ? (BASE_ADDR + OFF_P) : (BASE_ADDR + OFF_DONE);

`ifdef POLL_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Poll budget: held at zero through the START write, then counts every POLL/GAP cycle
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            to_cnt <= 32'd0;
        end else if (state == S_WR_START) begin
            to_cnt <= 32'd0;
        end else if ((state == S_POLL) || (state == S_GAP)) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    assign timed_out = (to_cnt >= (TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    // Job sequencer: drives every AXI channel and the local result interface from registers
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= S_IDLE;
            a_q           <= 4'd0;
            b_q           <= 4'd0;
            sel_q         <= 1'b0;
            xfer_active   <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            gap_cnt       <= 8'd0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_P           <= 30'd0;
            M_AXI_AWADDR  <= 32'd0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= 32'd0;
            M_AXI_WSTRB   <= 4'h0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= 32'd0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            o_done      <= 1'b0;
            M_AXI_WSTRB <= 4'hF;
            case (state)
                S_IDLE, S_FINISH: begin
                    state <= S_IDLE;
                    if (i_start_job) begin
                        a_q     <= i_A;
                        b_q     <= i_B;
                        sel_q   <= i_select;
                        o_error <= 1'b0;
                        o_busy  <= 1'b1;
                        state   <= S_WR_A;
                    end
                end

                S_WR_A, S_WR_B, S_WR_SEL, S_WR_START: begin
                    if (!xfer_active) begin
                        xfer_active   <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        M_AXI_AWADDR  <= wr_addr;
                        M_AXI_WDATA   <= wr_data;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                    end else begin
                        if (aw_hs) begin
                            M_AXI_AWVALID <= 1'b0;
                            aw_done       <= 1'b1;
                        end
                        if (w_hs) begin
                            M_AXI_WVALID <= 1'b0;
                            w_done       <= 1'b1;
                        end
                        // Response is only accepted once both address and data are through
                        if ((aw_done || aw_hs) && (w_done || w_hs) && !M_AXI_BREADY) begin
                            M_AXI_BREADY <= 1'b1;
                        end
                        if (b_hs) begin
                            M_AXI_BREADY <= 1'b0;
                            xfer_active  <= 1'b0;
                            if (M_AXI_BRESP != 2'b00) begin
                                o_error <= 1'b1;
                                o_done  <= 1'b1;
                                o_busy  <= 1'b0;
                                state   <= S_FINISH;
                            end else begin
                                state <= next_wr;
                            end
                        end
                    end
                end

                S_POLL, S_RD_P: begin
                    if (!xfer_active) begin
                        xfer_active   <= 1'b1;
                        M_AXI_ARADDR  <= rd_addr;
                        M_AXI_ARVALID <= 1'b1;
                    end else begin
                        if (ar_hs) begin
                            M_AXI_ARVALID <= 1'b0;
                            M_AXI_RREADY  <= 1'b1;
                        end
                        if (r_hs) begin
                            M_AXI_RREADY <= 1'b0;
                            xfer_active  <= 1'b0;
                            if (M_AXI_RRESP != 2'b00) begin
                                o_error <= 1'b1;
                                o_done  <= 1'b1;
                                o_busy  <= 1'b0;
                                state   <= S_FINISH;
                            end else if (state == S_RD_P) begin
                                o_P    <= M_AXI_RDATA[29:0];
                                o_done <= 1'b1;
                                o_busy <= 1'b0;
                                state  <= S_FINISH;
                            end else if (M_AXI_RDATA[0]) begin
                                state <= S_RD_P;
                            end else begin
                                gap_cnt <= 8'd0;
                                state   <= S_GAP;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (timed_out) begin
                        o_error <= 1'b1;
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= S_FINISH;
                    end else if (gap_cnt == 8'(POLL_GAP - 1)) begin
                        state <= S_POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/exp_mul_axi4_lite_master.md
Name: exp_mul_axi4_lite_master

Overview:
- AXI4-Lite master that runs one complete job on the exponent/multiplier register-mapped peripheral.
- Sequence: write A, B, SELECT and START; poll DONE; read P; return P to a simple local command interface.
- Sits between on-chip control logic (or a test harness) and the peripheral's AXI4-Lite slave port, so fabric logic can use the core without a processor.

Parameters:
- BASE_ADDR, 32'h74400000, peripheral base. Offsets fixed: A +0x0, B +0x4, SELECT +0x8, START +0xC, P +0x10, DONE +0x14.
- POLL_GAP, 4, idle cycles (1..255) between successive DONE reads.
- TIMEOUT_CYCLES, 1024, poll budget in cycles; used only when POLL_TIMEOUT_EN is defined.

Ports:
- M_AXI_ACLK in 1: single clock.
- M_AXI_ARESETN in 1: reset, asynchronous assert, active-low.
- i_start_job in 1: 1-cycle job request.
- i_A in 4: operand A.
- i_B in 4: operand B.
- i_select in 1: 0 = multiply, 1 = exponent.
- o_busy out 1: job in progress.
- o_done out 1: 1-cycle pulse at job end.
- o_error out 1: job ended on a bad response or timeout; valid with o_done.
- o_P out 30: result.
- M_AXI_AWADDR out 32; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out 32; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (M_AXI_ACLK, M_AXI_ARESETN). Every output is 0 while reset is low, including all VALID/READY, o_P, o_error and addresses. Reset mid-transaction aborts at once; no recovery of the partial job.
- Job FSM states: IDLE, WR_A, WR_B, WR_SEL, WR_START, POLL, GAP, RD_P, FINISH.
- IDLE:
  - i_start_job=1 latches i_A, i_B, i_select, clears o_error, sets o_busy, goes to WR_A.
  - i_start_job while o_busy=1 is ignored.
- Write data: WDATA = {28'b0,A}, {28'b0,B}, {31'b0,select}, 32'h1 respectively. WSTRB = 4'hF always.
- Write transaction:
  - AWVALID and WVALID rise in the same cycle. Each drops independently, the cycle after its own handshake.
  - AWADDR and WDATA stay stable while their VALID is high.
  - After both handshakes, BREADY=1 until BVALID. The next state is entered after the B handshake.
- Read transaction:
  - ARVALID stays high with ARADDR stable until ARREADY.
  - RREADY=1 from the cycle after the AR handshake until RVALID; RDATA is sampled on the R handshake.
- No VALID ever drops before its handshake. Only one outstanding transaction at a time.
- POLL:
  - Reads BASE+0x14.
  - RDATA[0]=1 goes to RD_P.
  - RDATA[0]=0 goes to GAP, waits POLL_GAP cycles, then returns to POLL.
  - The first DONE read is issued only after the START write response.
- RD_P: reads BASE+0x10, loads o_P <= RDATA[29:0], goes to FINISH.
- FINISH: o_done=1 for one cycle, o_busy drops in the same cycle, returns to IDLE.
- o_P holds its value until the next successful RD_P.
- Errors:
  - Any BRESP or RRESP != 2'b00 sets o_error. The current transaction completes its handshake, then FINISH.
  - No further AXI traffic is issued for that job.
  - o_P is not updated on an erroring job.

Optional Feature:
- Macro POLL_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to POLL from WR_START and counts every cycle spent in POLL/GAP.
  - Reaching TIMEOUT_CYCLES while in GAP sets o_error and goes to FINISH.
  - An in-flight read is always completed first.
- Undefined: no counter; polling is unbounded.

Test Plan:
- Multiply, zero-wait slave model: A=3, B=5, select=0 -> writes 0x74400000=3, 0x74400004=5, 0x74400008=0, 0x7440000C=1 in that order; DONE polled until 1; read 0x74400010 -> o_P=15, o_done pulse, o_error=0.
- Exponent: A=2, B=10, select=1 -> o_P=1024. Gap between DONE reads is >= POLL_GAP cycles.
- Backpressure: WREADY immediate, AWREADY held low 5 cycles -> WVALID drops after its handshake; AWVALID/AWADDR stay stable until AWREADY; BREADY only after both handshakes.
- Error: BRESP=2'b10 on the B write -> no SELECT/START/read traffic follows, o_error=1 with the o_done pulse, o_P unchanged.
- Reset in POLL with ARVALID=1 -> all outputs 0 asynchronously. After release, a new job with A=4, B=4, select=0 gives o_P=16; i_start_job pulsed mid-job is ignored.
- POLL_TIMEOUT_EN, DONE always 0, TIMEOUT_CYCLES=64 -> o_done with o_error=1 within 64 + POLL_GAP + one read latency.
